// File: rtl/pt2262_tx_scheduler.sv
// Round-robin scheduler sharing one PT2262-style encoder between NREQ requesters.
// Latches the winner's address/data, runs the encoder, and counts frames on sync falls.
module pt2262_tx_scheduler #(
  parameter int NREQ        = 4,
  parameter int MIN_FRAMES  = 4,
  parameter int MAX_FRAMES  = 15,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 200000,
  parameter int GAP_CYC     = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       req_addr,
  input  logic [4*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    err,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] active_id,
  output logic                    enc_rst,
  output logic [7:0]              enc_A,
  output logic [3:0]              enc_D,
  input  logic                    enc_sync
);

  localparam int IDW = $clog2(NREQ);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam int GW  = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  state_t state, state_nxt;

  logic [NREQ-1:0][7:0]   addr_v;
  logic [NREQ-1:0][3:0]   data_v;
  logic [IDW-1:0]         rr, win_id;
  logic                   win_vld;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   sync_hist, boundary;
  logic [3:0]             frame_cnt, frame_nxt;
  logic [TW-1:0]          tmr;
  logic [GW-1:0]          gap_cnt;
  logic                   held, others, keep_run;

  assign addr_v = req_addr;
  assign data_v = req_data;

  // First set request searching upward from the requester after the last winner.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(rr) + k) % NREQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  assign boundary  = (state == RUN) && sync_hist && !sync_pipe[SYNC_STAGES-1];
  assign frame_nxt = (frame_cnt == 4'hF) ? 4'hF : frame_cnt + 4'd1;
  assign held      = req[active_id];
  assign others    = |(req & ~(NREQ'(1) << active_id));
  // A sole requester holding its key keeps sending past the 15-frame saturation.
  assign keep_run  = (frame_nxt < 4'(MIN_FRAMES)) ||
                     (held && !others) ||
                     (held && (frame_nxt < 4'(MAX_FRAMES)));

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    done      = '0;
    err       = 1'b0;
    unique case (state)
      IDLE: if (win_vld) begin
        gnt[win_id] = 1'b1;
        state_nxt   = RUN;
      end
      RUN: begin
        if (boundary) begin
          if (!keep_run) begin
            done[active_id] = 1'b1;
            state_nxt       = GAP;
          end
        end else if (tmr == TW'(TIMEOUT_CYC)) begin
          err       = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: if (gap_cnt == GW'(GAP_CYC - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enc_rst = (state != RUN);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr        <= IDW'(NREQ - 1);
      active_id <= '0;
      enc_A     <= '0;
      enc_D     <= '0;
      frame_cnt <= '0;
      tmr       <= '0;
      gap_cnt   <= '0;
      sync_pipe <= '0;
      sync_hist <= 1'b0;
    end else begin
      state     <= state_nxt;
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], enc_sync};
      sync_hist <= sync_pipe[SYNC_STAGES-1];
      tmr       <= '0;
      gap_cnt   <= '0;
      unique case (state)
        IDLE: if (win_vld) begin
          enc_A     <= addr_v[win_id];
          enc_D     <= data_v[win_id];
          active_id <= win_id;
          rr        <= win_id;
          frame_cnt <= '0;
          // Stale sync history from the previous grant must not count as a boundary.
          sync_pipe <= '0;
          sync_hist <= 1'b0;
        end
        RUN: begin
          if (boundary) frame_cnt <= frame_nxt;
          else          tmr       <= tmr + TW'(1);
        end
        GAP: begin
          frame_cnt <= '0;
          gap_cnt   <= gap_cnt + GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pt2262_tx_scheduler.sv
// Bench for pt2262_tx_scheduler: behavioural encoder, transaction-level model of
// arbitration and frame-count rules, vector table plus randomized sessions.
module tb_pt2262_tx_scheduler;
  localparam int NREQ = 4, MINF = 4, MAXF = 15, SS = 2, TO = 300, GAP = 16, FP = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_addr;
  logic [15:0] req_data;
  logic [3:0]  gnt, done;
  logic        err, busy, enc_rst, enc_sync;
  logic [1:0]  active_id;
  logic [7:0]  enc_A;
  logic [3:0]  enc_D;

  int tests = 0, fails = 0;
  int m_rr  = NREQ - 1;
  int falls = 0;
  int ph    = 0;
  bit tie0  = 1'b0;

  typedef struct {
    logic [3:0] req;
    logic [7:0] addr;
    logic [3:0] data;
    logic [3:0] exp_gnt;
    int         exp_frames;
  } vec_t;
  vec_t tbl [8];

  pt2262_tx_scheduler #(.NREQ(NREQ), .MIN_FRAMES(MINF), .MAX_FRAMES(MAXF),
    .SYNC_STAGES(SS), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .busy(busy), .active_id(active_id),
    .enc_rst(enc_rst), .enc_A(enc_A), .enc_D(enc_D), .enc_sync(enc_sync));

  always #5 clk = ~clk;

  // Encoder stand-in: frames of FP cycles, sync high for the last 10, falling at the wrap.
  always @(negedge clk) begin
    if (enc_rst || tie0) ph <= 0;
    else if (ph == FP - 1) begin ph <= 0; falls <= falls + 1; end
    else ph <= ph + 1;
  end
  assign enc_sync = !enc_rst && !tie0 && (ph >= FP - 10);

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] m, input int rr);
    for (int k = 1; k <= NREQ; k++) if (m[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return 0;
  endfunction

  function automatic int idx_of(input logic [3:0] oh);
    for (int i = 0; i < NREQ; i++) if (oh[i]) return i;
    return 0;
  endfunction

  task automatic wait_gap();
    int cnt;
    bit bad;
    cnt = 0; bad = 1'b0;
    while (cnt < GAP + 5) begin
      tick();
      if (!busy) break;
      if (!enc_rst || gnt != 0 || done != 0 || err) bad = 1'b1;
      cnt++;
    end
    check("gap_len", cnt, GAP);
    check("gap_quiet", bad, 0);
  endtask

  // One grant: apply mask in IDLE, follow frames; winner's req drops after drop_at frames.
  task automatic session(input logic [3:0] mask, input int drop_at, input logic [3:0] exp_gnt,
                         input logic [7:0] a, input logic [3:0] d, output int frames);
    int w, n, k, f0;
    bit fin, held, oth, endx, dseen, errseen;
    logic [3:0] dval;
    w = idx_of(exp_gnt);
    req_addr = $urandom;
    req_data = 16'($urandom);
    req_addr[8*w +: 8] = a;
    req_data[4*w +: 4] = d;
    req = mask;
    #1;
    check("gnt", gnt, exp_gnt);
    check("idle_busy", busy, 0);
    m_rr = w;
    tick();
    check("run_state", {busy, enc_rst}, 2'b10);
    check("enc_A", enc_A, a);
    check("enc_D", enc_D, d);
    check("active_id", active_id, w);
    if (drop_at == 0) req[w] = 1'b0;
    req_addr = ~req_addr;
    req_data = ~req_data;
    n = 0; frames = 0; fin = 1'b0; errseen = 1'b0;
    while (!fin) begin
      f0 = falls; k = 0;
      while (falls == f0 && k < FP + 20) begin tick(); k++; if (err) errseen = 1'b1; end
      if (falls == f0) begin check("frame_wait", falls - f0, 1); break; end
      frames++;
      n = (n < 15) ? n + 1 : 15;
      held = req[w];
      oth  = |(req & ~(4'b1 << w));
      endx = !(n < MINF || (held && !oth) || (held && n < MAXF));
      dseen = 1'b0; dval = '0;
      for (int j = 0; j < 6; j++) begin
        tick();
        if (err) errseen = 1'b1;
        if (done != 0) begin dseen = 1'b1; dval = done; break; end
      end
      check("done_at_boundary", dseen, endx);
      check("enc_hold_run", {enc_A, enc_D}, {a, d});
      if (dseen) begin check("done_id", dval, exp_gnt); fin = 1'b1; end
      else if (endx || frames >= 40) fin = 1'b1;
      else if (frames >= drop_at) req[w] = 1'b0;
    end
    check("no_err", errseen, 0);
    wait_gap();
    check("enc_hold_idle", {enc_A, enc_D}, {a, d});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fr, f0, k, w;
    bit quiet;
    logic [3:0] mask;
    tbl[0] = '{4'b0001, 8'h5A, 4'h9, 4'b0001, 4};
    tbl[1] = '{4'b1111, 8'h3C, 4'h1, 4'b0010, 4};
    tbl[2] = '{4'b1111, 8'hC3, 4'h6, 4'b0100, 4};
    tbl[3] = '{4'b1001, 8'h00, 4'hF, 4'b1000, 4};
    tbl[4] = '{4'b0110, 8'hFF, 4'h0, 4'b0010, 4};
    tbl[5] = '{4'b0011, 8'h96, 4'hA, 4'b0001, 4};
    tbl[6] = '{4'b1100, 8'h69, 4'h5, 4'b0100, 4};
    tbl[7] = '{4'b0010, 8'h11, 4'h3, 4'b0010, 4};

    reset = 1'b1; req = '0; req_addr = '0; req_data = '0;
    repeat (3) tick();
    check("reset_outs", {enc_rst, busy, gnt, done, err}, {1'b1, 1'b0, 4'b0, 4'b0, 1'b0});
    check("reset_enc", {enc_A, enc_D, active_id}, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      session(tbl[i].req, 0, tbl[i].exp_gnt, tbl[i].addr, tbl[i].data, fr);
      check("tbl_frames", fr, tbl[i].exp_frames);
    end

    // Reset during the second frame aborts silently and rewinds the rotation.
    req = 4'b0010; #1;
    check("rst_gnt", gnt, 4'b1 << rr_pick(4'b0010, m_rr));
    tick();
    f0 = falls; k = 0;
    while (falls == f0 && k < FP + 20) begin tick(); k++; end
    check("rst_frame1", falls - f0, 1);
    repeat (15) tick();
    reset = 1'b1; req = '0;
    tick();
    check("rst_abort", {enc_rst, busy, gnt, done, err}, {1'b1, 1'b0, 4'b0, 4'b0, 1'b0});
    check("rst_enc", {enc_A, enc_D, active_id}, 0);
    reset = 1'b0;
    m_rr = NREQ - 1;
    quiet = 1'b1;
    repeat (50) begin tick(); if (done != 0 || err || busy) quiet = 1'b0; end
    check("rst_quiet", quiet, 1);
    session(4'b1111, 0, 4'b0001, 8'hA5, 4'h7, fr);
    check("rst_first_frames", fr, 4);

    // Two held requesters share at MAX_FRAMES each, then rotation returns.
    session(4'b1010, 99, 4'b0010, 8'h12, 4'h4, fr);
    check("pair_frames_a", fr, 15);
    session(4'b1010, 99, 4'b1000, 8'h34, 4'h8, fr);
    check("pair_frames_b", fr, 15);
    session(4'b0010, 0, 4'b0010, 8'h56, 4'hC, fr);
    check("pair_frames_c", fr, 4);

    // Sole key held for 20 frames: continues through saturation until release.
    session(4'b0010, 20, 4'b0010, 8'h78, 4'hE, fr);
    check("held_frames", fr, 21);

    // Encoder sync stuck low: timeout error, no done.
    tie0 = 1'b1;
    req_addr = $urandom;
    req = 4'b0100; #1;
    check("to_gnt", gnt, 4'b1 << rr_pick(4'b0100, m_rr));
    tick();
    req = '0; m_rr = 2;
    k = 0; quiet = 1'b1;
    while (!err && k < TO + 20) begin tick(); k++; if (done != 0) quiet = 1'b0; end
    check("timeout_cycles", k, TO);
    check("timeout_no_done", quiet, 1);
    wait_gap();
    tie0 = 1'b0;

    for (int i = 0; i < 12; i++) begin
      mask = req | 4'($urandom_range(0, 15));
      if (mask == 0) mask = 4'b1 << $urandom_range(0, 3);
      w = rr_pick(mask, m_rr);
      session(mask, $urandom_range(0, 18), 4'b1 << w, 8'($urandom), 4'($urandom), fr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
